// File: rtl/decodificador.sv
// decodificador: decodes 4-bit codifier codewords into source values 0..11.
// Each accepted codeword is buffered as {err, value} in a first-word-fall-through
// FIFO behind a valid/ready handshake. Invalid codes (1, 3, 9, 12) are kept in
// the stream as value 4'hF with err=1 and are never dropped.
// Optional build macro DECODIFICADOR_ERRCNT_EN adds a saturating 8-bit counter
// of accepted invalid codewords; without it err_count is tied to zero.
module decodificador #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [3:0]               code_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [3:0]               data_out,
    output logic                     code_err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [4:0]    dec_entry;
    logic          push;
    logic          pop;

    // Handshake flags come straight from the occupancy register, so no input
    // can reach them combinationally (no pass-through when full).
    assign in_ready  = (level_q != LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign level     = level_q;

    // Codeword to {err, value} lookup; unused codes map to {1, 4'hF}.
    always_comb begin
        dec_entry = 5'h1F;
        unique case (code_in)
            4'd14:   dec_entry = 5'd0;
            4'd10:   dec_entry = 5'd1;
            4'd4:    dec_entry = 5'd2;
            4'd13:   dec_entry = 5'd3;
            4'd6:    dec_entry = 5'd4;
            4'd5:    dec_entry = 5'd5;
            4'd7:    dec_entry = 5'd6;
            4'd15:   dec_entry = 5'd7;
            4'd0:    dec_entry = 5'd8;
            4'd11:   dec_entry = 5'd9;
            4'd2:    dec_entry = 5'd10;
            4'd8:    dec_entry = 5'd11;
            default: dec_entry = 5'h1F;
        endcase
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clock) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= dec_entry;
        end
    end

    // Pointers and occupancy; a push or pop during reset is discarded.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Head entry is shown only while something is buffered, zero otherwise.
    always_comb begin
        data_out = 4'd0;
        code_err = 1'b0;
        if (out_valid) begin
            data_out = mem[rd_ptr][3:0];
            code_err = mem[rd_ptr][4];
        end
    end

`ifdef DECODIFICADOR_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Count accepted invalid codewords, holding at 255.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err_cnt_q <= 8'd0;
        end else if (push && dec_entry[4] && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_decodificador.sv
// Bench for decodificador: directed stimulus, a queue-based model of the
// decoder + FIFO checked every cycle, and literal expectations at key points.
module tb_decodificador;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [3:0]    code_in;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    data_out;
    logic          code_err;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic [7:0]    err_count;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    logic [4:0] model_q[$];
    int         model_err = 0;
    logic [3:0] out_log[$];
    int         code_tbl[12] = '{14, 10, 4, 13, 6, 5, 7, 15, 0, 11, 2, 8};

    decodificador #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .code_in   (code_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .code_err  (code_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .err_count (err_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Source value is the position of the code in the table; otherwise invalid.
    function automatic logic [4:0] model_decode(input logic [3:0] c);
        for (int i = 0; i < 12; i++) begin
            if (code_tbl[i] == int'(c)) return {1'b0, 4'(i)};
        end
        return 5'h1F;
    endfunction

    function automatic int exp_err();
`ifdef DECODIFICADOR_ERRCNT_EN
        return model_err;
`else
        return 0;
`endif
    endfunction

    // Model update and output logging at each rising edge.
    always @(posedge clock) begin
        if (!reset_n) begin
            model_q.delete();
            model_err = 0;
            armed = 1'b1;
        end else if (armed) begin
            bit do_push;
            bit do_pop;
            logic [4:0] e;
            do_push = in_valid && (model_q.size() < DEPTH);
            do_pop  = out_ready && (model_q.size() > 0);
            if (out_valid && out_ready) out_log.push_back(data_out);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e = model_decode(code_in);
                model_q.push_back(e);
                if (e[4] && model_err < 255) model_err++;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (armed) begin
            int n;
            n = model_q.size();
            chk("level", int'(level), n);
            chk("out_valid", int'(out_valid), int'(n != 0));
            chk("in_ready", int'(in_ready), int'(n != DEPTH));
            chk("data_out", int'(data_out), (n != 0) ? int'(model_q[0][3:0]) : 0);
            chk("code_err", int'(code_err), (n != 0) ? int'(model_q[0][4]) : 0);
            chk("err_count", int'(err_count), exp_err());
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit accepted;
        int guard;
        int inv_codes[4] = '{1, 3, 9, 12};

        reset_n   = 1'b0;
        in_valid  = 1'b1;
        code_in   = 4'd14;
        out_ready = 1'b0;

        // Reset held two cycles with in_valid asserted: nothing buffered.
        step();
        step();
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_err_count", int'(err_count), 0);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        step();

        // Full valid sweep, drained every cycle.
        out_log.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            code_in  = 4'(code_tbl[i]);
            step();
            chk("sweep_lat_valid", int'(out_valid), 1);
            chk("sweep_lat_data", int'(data_out), i);
        end
        in_valid = 1'b0;
        step();
        step();
        chk("sweep_count", out_log.size(), 12);
        for (int i = 0; i < 12 && i < out_log.size(); i++) chk("sweep_order", int'(out_log[i]), i);

        // Invalid codes buffered with back-pressure.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            code_in  = 4'(inv_codes[i]);
            step();
        end
        in_valid = 1'b0;
        chk("inv_level", int'(level), 4);
        chk("inv_data", int'(data_out), 15);
        chk("inv_err", int'(code_err), 1);
`ifdef DECODIFICADOR_ERRCNT_EN
        chk("inv_errcnt", int'(err_count), 4);
`else
        chk("inv_errcnt", int'(err_count), 0);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("inv_drained", int'(level), 0);

        // Back-pressure: fill, hold a fifth word, then release.
        out_log.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            code_in  = 4'(code_tbl[i]);
            step();
        end
        in_valid = 1'b1;
        code_in  = 4'd6;
        step();
        chk("bp_level", int'(level), 4);
        chk("bp_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        guard = 0;
        do begin
            accepted = in_ready;
            step();
            guard++;
        end while (!accepted && guard < 10);
        chk("bp_accept_guard", int'(accepted), 1);
        chk("bp_accept_cycles", guard, 2);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("bp_count", out_log.size(), 5);
        for (int i = 0; i < 5 && i < out_log.size(); i++) chk("bp_order", int'(out_log[i]), i);

        // Reset mid-operation with level 3.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            code_in  = 4'd1;
            step();
        end
        chk("mid_level_before", int'(level), 3);
        reset_n   = 1'b0;
        out_ready = 1'b1;
        code_in   = 4'd5;
        step();
        chk("mid_level", int'(level), 0);
        chk("mid_out_valid", int'(out_valid), 0);
        chk("mid_err_count", int'(err_count), 0);
        reset_n  = 1'b1;
        out_log.delete();
        in_valid = 1'b1;
        code_in  = 4'd7;
        step();
        in_valid = 1'b0;
        step();
        chk("mid_first_count", out_log.size(), 1);
        if (out_log.size() > 0) chk("mid_first_word", int'(out_log[0]), 6);

        // Saturation: 300 invalid codewords while draining.
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            code_in  = 4'd12;
            step();
            if (i == 254) begin
`ifdef DECODIFICADOR_ERRCNT_EN
                chk("sat_reach", int'(err_count), 255);
`else
                chk("sat_reach", int'(err_count), 0);
`endif
            end
        end
        in_valid = 1'b0;
        step();
        step();
`ifdef DECODIFICADOR_ERRCNT_EN
        chk("sat_hold", int'(err_count), 255);
`else
        chk("sat_hold", int'(err_count), 0);
`endif
        chk("final_level", int'(level), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decodificador.md
# decodificador

Streaming decoder that converts 4-bit codewords produced by the team's 4-bit codifier back into their source values 0..11. Accepted codewords are decoded, tagged with a validity flag and buffered in a small first-word-fall-through FIFO behind a valid/ready handshake. The block sits on the receive side of the codifier link, between the codeword source and downstream consumers, and absorbs consumer back-pressure.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- Clock  in  1  rising-edge clock
- Reset_n  in  1  synchronous, active-low reset
- Code_in  in  4  codeword
- In_valid  in  1  Code_in is valid this cycle
- In_ready  out  1  block can accept a codeword; equals not full
- Data_out  out  4  decoded value, 0..11; 4'hF for an invalid codeword
- Code_err  out  1  head entry came from an invalid codeword
- Out_valid  out  1  head entry present; equals not empty
- Out_ready  in  1  consumer takes the head entry
- Level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- Err_count  out  8  saturating count of invalid codewords accepted

## Operation
- Accept: In_valid & In_ready at a rising edge. Pop: Out_valid & Out_ready at a rising edge.
- Decode map (code→value): 14→0, 10→1, 4→2, 13→3, 6→4, 5→5, 7→6, 15→7, 0→8, 11→9, 2→10, 8→11.
- Codes 1, 3, 9, 12 are invalid: stored as value 4'hF with error flag 1. They are still accepted and still occupy an entry. They are never dropped.
- Each FIFO entry holds 5 bits: {err, value}.
- Data_out and Code_err reflect the head entry while Out_valid=1. They are 0 while empty.
- Pointers: write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Level update per cycle: +1 on push only, −1 on pop only, unchanged on push+pop.
- Full (Level=DEPTH): In_ready=0. An In_valid arriving while full is not accepted; the source holds it. There is no same-cycle pass-through: a simultaneous pop while full does not raise In_ready in that cycle.
- Empty (Level=0): Out_valid=0, and Out_ready is ignored.
- Push+pop in the same cycle at any level between 1 and DEPTH−1: both take effect and ordering is preserved.

## Timing
- Reset values (Reset_n=0 sampled at an edge):
  - Level=0, pointers=0, Out_valid=0, In_ready=1, Data_out=0, Code_err=0, Err_count=0.
  - FIFO contents are don't-care.
- Reset mid-operation: all entries are flushed. Words already buffered never appear on Data_out. A push or pop requested in the reset cycle is ignored.
- Latency: a codeword accepted at edge N is visible on Data_out/Out_valid after edge N, when the FIFO was empty. Otherwise it appears after all older entries have been popped.
- In_ready, Out_valid, Data_out, Code_err, Level and Err_count are all registered or derived only from registers. None has a combinational path from any input.
- Throughput: one codeword per cycle sustained while Out_ready=1.

## Configuration
- DECODIFICADOR_ERRCNT_EN defined:
  - Err_count increments by 1 on each accepted invalid codeword.
  - It saturates at 255 and clears only on reset.
- Not defined:
  - Err_count is tied to 8'd0 and no counter logic is built.
  - Code_err and the 4'hF substitution remain in both builds.

## Test plan
- Reset: hold Reset_n=0 for 2 cycles with In_valid=1 → In_ready=1, Out_valid=0, Level=0, Err_count=0, nothing buffered.
- Full valid sweep: stream codes 14,10,4,13,6,5,7,15,0,11,2,8 back-to-back with Out_ready=1 → Data_out=0..11 in order, Code_err=0, each one cycle after acceptance, Level ≤1.
- Invalid codes: send 1, 3, 9, 12 → four entries with Data_out=4'hF and Code_err=1. Err_count=4 with the macro, 0 without.
- Back-pressure (DEPTH=4): hold Out_ready=0 and push codes 14,10,4,13 → Level=4, In_ready=0, a 5th code 6 is held. Then raise Out_ready=1 → output is 0,1,2,3,4 with no loss or duplication.
- Reset mid-operation: with Level=3, pulse Reset_n=0 for one cycle → Level=0 and Out_valid=0 next cycle. Then push code 7 → Data_out=6 is the first word out.
- Saturation (macro on): push 300 invalid codes while draining → Err_count=255 and stays at 255.
